// File: rtl/ifmap_mem_mt.sv
// ifmap_mem_mt: NUM_TS binary DIM x DIM spike maps, loaded bitwise, then served row-by-row to router requests.
module ifmap_mem_mt #(
  parameter int DIM = 25,
  parameter int NUM_TS = 2,
  parameter int PKT_W = 33,
  parameter logic [3:0] MY_ADDR = 4'd11,
  parameter logic [3:0] OP_ROW = 4'd1,
  parameter logic [3:0] OP_EOT = 4'd15,
  parameter logic [3:0] OP_RESP = 4'd2,
  localparam int TSW = NUM_TS > 1 ? $clog2(NUM_TS) : 1,
  localparam int RW = DIM > 1 ? $clog2(DIM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [TSW-1:0]   ld_ts,
  input  logic [RW-1:0]    ld_row,
  input  logic [RW-1:0]    ld_col,
  input  logic             ld_bit,
  input  logic             load_done,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PKT_W-1:0] req_pkt,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [PKT_W-1:0] resp_pkt,
  output logic [TSW-1:0]   cur_ts,
  output logic             ts_done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, LOAD, SERVE, RESP} state_t;
  localparam logic [TSW:0] TS_N = (TSW+1)'(NUM_TS);
  localparam logic [RW:0] DIM_N = (RW+1)'(DIM);
  localparam logic [TSW-1:0] TS_LAST = TSW'(NUM_TS - 1);
  state_t state_q;
  logic [DIM-1:0] mem_q [NUM_TS][DIM];
  logic resp_valid_q, ts_done_q, err_q;
  logic [PKT_W-1:0] resp_pkt_q;
  logic [TSW-1:0] cur_ts_q;
  logic ld_fire, ld_in_range, row_ok;
  logic [3:0] req_op;
  logic [RW-1:0] req_row;
  logic [DIM-1:0] row_bits;
  logic [24:0] row_data;
  logic unused_req_bits;
  assign ld_ready = state_q == LOAD;
  assign req_ready = state_q == SERVE;
  assign resp_valid = resp_valid_q;
  assign resp_pkt = resp_pkt_q;
  assign cur_ts = cur_ts_q;
  assign ts_done = ts_done_q;
  assign err = err_q;
  assign ld_fire = ld_valid && ld_ready;
  assign ld_in_range = ({1'b0, ld_ts} < TS_N) && ({1'b0, ld_row} < DIM_N) && ({1'b0, ld_col} < DIM_N);
  assign req_op = req_pkt[28:25];
  assign req_row = req_pkt[RW-1:0];
  assign row_ok = {1'b0, req_row} < DIM_N;
  assign row_bits = row_ok ? mem_q[cur_ts_q][req_row] : '0;
  // Rows wider than 21 bits overlap the source-address field; the spike bits take precedence there.
  assign row_data = (DIM <= 21 ? {MY_ADDR, 21'b0} : 25'b0) | 25'(row_bits);
  assign unused_req_bits = ^{req_pkt[PKT_W-1:29], req_pkt[20:RW]};
  always_ff @(posedge clk)
    if (state_q == IDLE && load_start)
      for (int t = 0; t < NUM_TS; t++)
        for (int r = 0; r < DIM; r++)
          mem_q[t][r] <= '0;
    else if (ld_fire && ld_in_range)
      mem_q[ld_ts][ld_row][ld_col] <= ld_bit;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      resp_valid_q <= 1'b0;
      resp_pkt_q <= '0;
      cur_ts_q <= '0;
      ts_done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ts_done_q <= 1'b0;
      case (state_q)
        IDLE: if (load_start) state_q <= LOAD;
        LOAD: begin
          if (ld_fire && !ld_in_range) err_q <= 1'b1;
          if (load_done) begin
            state_q <= SERVE;
            cur_ts_q <= '0;
          end
        end
        SERVE: if (req_valid) begin
          if (req_op == OP_ROW) begin
            resp_pkt_q <= PKT_W'({req_pkt[24:21], OP_RESP, row_data});
            resp_valid_q <= 1'b1;
            state_q <= RESP;
            if (!row_ok) err_q <= 1'b1;
          end else if (req_op == OP_EOT) begin
            ts_done_q <= 1'b1;
            cur_ts_q <= cur_ts_q == TS_LAST ? '0 : cur_ts_q + TSW'(1);
            if (cur_ts_q == TS_LAST) state_q <= IDLE;
          end else err_q <= 1'b1;
        end
        RESP: if (resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q <= SERVE;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ifmap_mem_mt.sv
// tb_ifmap_mem_mt: scoreboard bench; a small DIM=5/NUM_TS=2 instance for directed cases, a DIM=25/NUM_TS=4 one for a full random map.
module tb_ifmap_mem_mt;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic rst, load_start, ld_valid, ld_bit, load_done, req_valid, resp_ready;
  logic ld_ts;
  logic [2:0] ld_row, ld_col;
  logic [32:0] req_pkt, resp_pkt;
  logic ld_ready, req_ready, resp_valid, ts_done, err, cur_ts;
  logic b_load_start, b_ld_valid, b_ld_bit, b_load_done, b_req_valid, b_resp_ready;
  logic [1:0] b_ld_ts, b_cur_ts;
  logic [4:0] b_ld_row, b_ld_col;
  logic [32:0] b_req_pkt, b_resp_pkt;
  logic b_ld_ready, b_req_ready, b_resp_valid, b_ts_done, b_err;
  logic [32:0] qa[$], qb[$];
  logic [24:0] gold [4][25];
  ifmap_mem_mt #(.DIM(5), .NUM_TS(2)) dut_a (
    .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_ts(ld_ts), .ld_row(ld_row), .ld_col(ld_col), .ld_bit(ld_bit), .load_done(load_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_pkt(req_pkt), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_pkt(resp_pkt), .cur_ts(cur_ts), .ts_done(ts_done), .err(err));
  ifmap_mem_mt #(.DIM(25), .NUM_TS(4)) dut_b (
    .clk(clk), .rst(rst), .load_start(b_load_start), .ld_valid(b_ld_valid), .ld_ready(b_ld_ready),
    .ld_ts(b_ld_ts), .ld_row(b_ld_row), .ld_col(b_ld_col), .ld_bit(b_ld_bit), .load_done(b_load_done),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pkt(b_req_pkt), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_pkt(b_resp_pkt), .cur_ts(b_cur_ts), .ts_done(b_ts_done), .err(b_err));
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [32:0] exp_a(input logic [3:0] ret, input logic [4:0] bits);
    return {ret, 4'd2, 4'd11, 16'd0, bits};
  endfunction
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (qa.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL a_unexpected_resp: got %0h expected no response", resp_pkt);
      end else check("a_resp_pkt", resp_pkt, qa.pop_front());
    end
    if (b_resp_valid && b_resp_ready) begin
      if (qb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL b_unexpected_resp: got %0h expected no response", b_resp_pkt);
      end else check("b_resp_pkt", b_resp_pkt, qb.pop_front());
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic a_ld(input int ts, input int row, input int col, input logic b, input logic done);
    ld_valid = 1'b1; ld_ts = ts[0]; ld_row = row[2:0]; ld_col = col[2:0]; ld_bit = b; load_done = done;
    tick;
    ld_valid = 1'b0; load_done = 1'b0;
  endtask
  task automatic a_row(input int ts, input int row, input logic [4:0] bits);
    for (int c = 0; c < 5; c++) a_ld(ts, row, c, bits[c], 1'b0);
  endtask
  task automatic a_req(input logic [3:0] op, input logic [3:0] ret, input int row);
    int k = 0;
    while (!req_ready && k < 50) begin tick; k++; end
    if (!req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL a_req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1; req_pkt = {4'd0, op, ret, 16'd0, 5'(row)};
    tick;
    req_valid = 1'b0;
  endtask
  task automatic b_req(input logic [3:0] op, input logic [3:0] ret, input int row);
    int k = 0;
    while (!b_req_ready && k < 50) begin tick; k++; end
    if (!b_req_ready) begin
      n_chk++; n_fail++;
      $display("FAIL b_req_ready_timeout: got 0 expected 1");
    end
    b_req_valid = 1'b1; b_req_pkt = {4'd0, op, ret, 16'd0, 5'(row)};
    tick;
    b_req_valid = 1'b0;
  endtask
  task automatic a_pulse_start;
    load_start = 1'b1; tick; load_start = 1'b0;
  endtask
  task automatic a_pulse_done;
    load_done = 1'b1; tick; load_done = 1'b0;
  endtask
  task automatic a_outputs_zero(input string tag);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_pkt"}, resp_pkt, 0);
    check({tag, "_cur_ts"}, cur_ts, 0);
    check({tag, "_ts_done"}, ts_done, 0);
    check({tag, "_err"}, err, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1; load_start = 0; ld_valid = 0; ld_bit = 0; load_done = 0; req_valid = 0; resp_ready = 1;
    ld_ts = 0; ld_row = 0; ld_col = 0; req_pkt = '0;
    b_load_start = 0; b_ld_valid = 0; b_ld_bit = 0; b_load_done = 0; b_req_valid = 0; b_resp_ready = 1;
    b_ld_ts = 0; b_ld_row = 0; b_ld_col = 0; b_req_pkt = '0;
    tick; tick;
    a_outputs_zero("reset");
    rst = 0;
    a_pulse_start;
    check("ld_ready_in_load", ld_ready, 1);
    a_row(0, 2, 5'b10110);
    a_row(1, 2, 5'b01001);
    a_row(0, 0, 5'b00011);
    a_ld(1, 4, 4, 1'b1, 1'b1);
    check("ld_ready_after_done", ld_ready, 0);
    check("req_ready_serve", req_ready, 1);
    check("err_after_load", err, 0);
    resp_ready = 0;
    qa.push_back(exp_a(4'd7, 5'b10110));
    a_req(4'd1, 4'd7, 2);
    check("resp_latency", resp_valid, 1);
    repeat (10) begin
      check("hold_pkt", resp_pkt, {4'd7, 4'd2, 4'd11, 16'd0, 5'b10110});
      check("hold_req_ready", req_ready, 0);
      tick;
    end
    resp_ready = 1;
    tick;
    check("resp_valid_after_hs", resp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
    check("a_drain_hold", qa.size(), 0);
    qa.push_back(exp_a(4'd3, 5'b00011));
    a_req(4'd1, 4'd3, 0);
    a_req(4'd15, 4'd0, 0);
    check("eot1_ts_done", ts_done, 1);
    check("eot1_cur_ts", cur_ts, 1);
    tick;
    check("eot1_ts_done_drop", ts_done, 0);
    qa.push_back(exp_a(4'd5, 5'b01001));
    a_req(4'd1, 4'd5, 2);
    qa.push_back(exp_a(4'd1, 5'b10000));
    a_req(4'd1, 4'd1, 4);
    check("err_clean", err, 0);
    qa.push_back(exp_a(4'd2, 5'b00000));
    a_req(4'd1, 4'd2, 7);
    check("err_bad_row", err, 1);
    a_req(4'd15, 4'd0, 0);
    check("eot2_ts_done", ts_done, 1);
    check("eot2_cur_ts", cur_ts, 0);
    check("eot2_idle_req_ready", req_ready, 0);
    check("eot2_idle_ld_ready", ld_ready, 0);
    rst = 1; tick; rst = 0;
    a_pulse_start;
    a_ld(0, 1, 5, 1'b1, 1'b0);
    check("err_bad_col", err, 1);
    a_pulse_done;
    qa.push_back(exp_a(4'd4, 5'b00000));
    a_req(4'd1, 4'd4, 1);
    rst = 1; tick; rst = 0;
    a_pulse_start;
    a_pulse_done;
    check("err_before_op9", err, 0);
    a_req(4'd9, 4'd0, 0);
    tick;
    check("err_op9", err, 1);
    check("op9_no_resp", resp_valid, 0);
    rst = 1; tick; rst = 0;
    a_pulse_start;
    a_ld(0, 2, 1, 1'b1, 1'b0);
    a_pulse_done;
    resp_ready = 0;
    a_req(4'd1, 4'd9, 2);
    check("pre_rst_resp_valid", resp_valid, 1);
    rst = 1; tick;
    a_outputs_zero("mid_resp_rst");
    rst = 0; resp_ready = 1;
    a_pulse_start;
    a_ld(0, 1, 0, 1'b1, 1'b0);
    a_pulse_done;
    qa.push_back(exp_a(4'd6, 5'b00000));
    a_req(4'd1, 4'd6, 2);
    qa.push_back(exp_a(4'd8, 5'b00001));
    a_req(4'd1, 4'd8, 1);
    tick; tick;
    check("a_drain_final", qa.size(), 0);
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 25; r++)
        gold[t][r] = 25'($urandom);
    b_load_start = 1; tick; b_load_start = 0;
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 25; r++)
        for (int c = 0; c < 25; c++) begin
          b_ld_valid = 1; b_ld_ts = 2'(t); b_ld_row = 5'(r); b_ld_col = 5'(c); b_ld_bit = gold[t][r][c];
          tick;
        end
    b_ld_valid = 0;
    b_load_done = 1; tick; b_load_done = 0;
    for (int t = 0; t < 4; t++) begin
      check("b_cur_ts", b_cur_ts, t);
      for (int r = 0; r < 25; r++) begin
        qb.push_back({4'(r), 4'd2, gold[t][r]});
        b_req(4'd1, 4'(r), r);
      end
      b_req(4'd15, 4'd0, 0);
      check("b_ts_done", b_ts_done, 1);
    end
    check("b_idle_req_ready", b_req_ready, 0);
    check("b_wrap_cur_ts", b_cur_ts, 0);
    check("b_err", b_err, 0);
    tick; tick;
    check("b_drain_final", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
